onehot_decoder_seq: RTL

Parametrised, registered binary-to-one-hot decoder with enable. It adds an autonomous scan mode that walks the active output across all 2^SEL_W lines with a programmable dwell time, direction control and a wrap indication. It is the general successor to the combinational 3-to-8 decoder. It serves as the select generator for multiplexed displays, LED scanners and round-robin channel strobes.

---
 rtl/onehot_decoder_seq.sv | 94 +++++++++
 1 files changed

// File: rtl/onehot_decoder_seq.sv
// Registered binary-to-one-hot decoder with an autonomous scan mode that walks
// the active line with a programmable dwell, direction control and wrap pulse.
module onehot_decoder_seq #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      x,
    input  logic                  dir,
    input  logic                  hold,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [2**SEL_W-1:0]   y,
    output logic [SEL_W-1:0]      idx,
    output logic                  valid,
    output logic                  wrap
);
    localparam int OUT_W = 2 ** SEL_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [DWELL_W-1:0] cnt_reg, cnt_next;
    logic [SEL_W-1:0]   idx_next;
    logic               wrap_next;
    logic               valid_next;
    logic [OUT_W-1:0]   y_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx       <= '0;
            y         <= '0;
            valid     <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx       <= idx_next;
            y         <= y_next;
            valid     <= valid_next;
            wrap      <= wrap_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx;
        wrap_next  = 1'b0;
        if (!en) begin
            state_next = IDLE;
            cnt_next   = '0;
            idx_next   = '0;
        end else if (!mode) begin
            state_next = DIRECT;
            cnt_next   = '0;
            idx_next   = x;
        end else if (state_reg != SCAN) begin
            state_next = SCAN;
            cnt_next   = dwell;
            idx_next   = x;
        end else if (hold) begin
            // Frozen: counter and position keep their values, no wrap pulse.
            state_next = SCAN;
        end else if (cnt_reg != '0) begin
            cnt_next = cnt_reg - DWELL_W'(1);
        end else begin
            cnt_next = dwell;
            if (dir) begin
                idx_next  = idx - SEL_W'(1);
                wrap_next = (idx == '0);
            end else begin
                idx_next  = idx + SEL_W'(1);
                wrap_next = (&idx);
            end
        end
    end

    assign valid_next = (state_next != IDLE);

    // Each output line lights when the next index selects it and the block is active.
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_onehot
        assign y_next[gi] = valid_next && (idx_next == SEL_W'(gi));
    end

endmodule
